instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/riscv_pkg.sv | 18 +
 rtl/fetch_pc_gen.sv | 45 ++++
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the instruction fetch slice.
//   - fetch_state_e : fetch FSM states (BOOT / RUN / TRAP)
//   - XLEN_DEF      : default PC / instruction width
//   - RESET_PC_DEF  : default first fetch byte address
//   - PC_INCR       : sequential PC increment in bytes
package riscv_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INCR      = 4;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program counter register with next-PC selection.
// Ports:
//   clk_i      : clock, rising edge
//   rst_i      : asynchronous active-high reset, loads RESET_PC
//   redirect_i : load target_i into the PC (highest priority)
//   target_i   : redirect target byte address
//   advance_i  : step the PC by PC_INCR (wraps modulo 2^XLEN)
//   pc_o       : current PC
module fetch_pc_gen
    import riscv_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    always_comb begin
        pc_d = pc_q;
        if (redirect_i) begin
            pc_d = target_i;
        end else if (advance_i) begin
            pc_d = pc_q + XLEN'(PC_INCR);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-stage fetch with IF/ID register and valid/ready
// handshake toward decode.
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-high reset
//   imem_addr      : word address into instruction memory (pc[AW+1:2])
//   imem_rdata     : combinational read data for imem_addr
//   redirect_valid : branch/jump redirect request, overrides load/stall
//   redirect_pc    : redirect target byte address
//   out_valid      : IF/ID register holds a valid instruction
//   out_ready      : decode accepts the IF/ID entry this cycle
//   out_instr      : fetched instruction
//   out_pc         : byte address of out_instr
//   misalign_trap  : sticky misaligned-redirect flag
// Build option FETCH_MISALIGN_TRAP_EN: when defined, a redirect to a
// non-word-aligned target enters TRAP (left only by reset). When undefined
// the low two target bits are dropped and misalign_trap is tied low.
//
// state | meaning
// BOOT  | one cycle after reset, no capture; a redirect still loads the PC
// RUN   | fetching; capture when the IF/ID slot is empty or being drained
// TRAP  | misaligned redirect seen; PC frozen, out_valid low, redirects ignored
module instruction_fetch
    import riscv_pkg::*;
#(
    parameter int              DEPTH    = 256,
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [$clog2(DEPTH)-1:0] imem_addr,
    input  logic [XLEN-1:0]          imem_rdata,
    input  logic                     redirect_valid,
    input  logic [XLEN-1:0]          redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [XLEN-1:0]          out_instr,
    output logic [XLEN-1:0]          out_pc,
    output logic                     misalign_trap
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic            misaligned;
    logic            pc_redirect;
    logic            pc_advance;

    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;

    // Target is always word aligned; a misaligned request either traps or
    // silently drops its low bits, depending on the build.
    assign target = {redirect_pc[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
    assign misaligned = (redirect_pc[1:0] != 2'b00);
`else
    logic unused_low_bits;
    assign unused_low_bits = ^redirect_pc[1:0];
    assign misaligned      = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        pc_redirect = 1'b0;
        pc_advance  = 1'b0;
        valid_d     = valid_q;
        instr_d     = instr_q;
        opc_d       = opc_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (redirect_valid) begin
                    if (misaligned) begin
                        state_d = TRAP;
                    end else begin
                        pc_redirect = 1'b1;
                    end
                end
            end
            RUN: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (misaligned) begin
                        state_d = TRAP;
                    end else begin
                        pc_redirect = 1'b1;
                    end
                end else if (!valid_q || out_ready) begin
                    valid_d    = 1'b1;
                    instr_d    = imem_rdata;
                    opc_d      = pc;
                    pc_advance = 1'b1;
                end
            end
            TRAP: begin
                valid_d = 1'b0;
            end
            default: begin
                state_d = BOOT;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    fetch_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk_i      (clk),
        .rst_i      (rst),
        .redirect_i (pc_redirect),
        .target_i   (target),
        .advance_i  (pc_advance),
        .pc_o       (pc)
    );

    // PCs beyond the memory simply alias onto it.
    assign imem_addr = pc[AW+1:2];
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_trap = (state_q == TRAP);
`else
    assign misalign_trap = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_trap;

    logic [31:0] mem [256];
    int          checks;
    int          errors;

    instruction_fetch #(
        .DEPTH    (256),
        .XLEN     (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_trap  (misalign_trap)
    );

    assign imem_rdata = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        e_valid;
        logic        chk_data;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic [7:0]  e_addr;
        logic        e_trap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic cd, input logic [31:0] epc,
                       input logic [31:0] ein, input logic [7:0] ea, input logic et);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_valid = ev; v.chk_data = cd;
        v.e_pc = epc; v.e_instr = ein; v.e_addr = ea; v.e_trap = et;
        vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input string tag, input vec_t v);
        redirect_valid = v.rv;
        redirect_pc    = v.rpc;
        out_ready      = v.rdy;
        @(posedge clk);
        #1;
        chk({tag, " out_valid"}, {31'd0, out_valid}, {31'd0, v.e_valid});
        chk({tag, " imem_addr"}, {24'd0, imem_addr}, {24'd0, v.e_addr});
        chk({tag, " misalign_trap"}, {31'd0, misalign_trap}, {31'd0, v.e_trap});
        if (v.chk_data) begin
            chk({tag, " out_pc"}, out_pc, v.e_pc);
            chk({tag, " out_instr"}, out_instr, v.e_instr);
        end
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step($sformatf("row%0d", i), vecs[i]);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, " out_pc"}, out_pc, 32'd0);
        chk({tag, " out_instr"}, out_instr, 32'd0);
        chk({tag, " misalign_trap"}, {31'd0, misalign_trap}, 32'd0);
        chk({tag, " imem_addr"}, {24'd0, imem_addr}, 32'd0);
    endtask

    task automatic one(input string tag, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic ev, input logic cd,
                       input logic [31:0] epc, input logic [31:0] ein,
                       input logic [7:0] ea, input logic et);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_valid = ev; v.chk_data = cd;
        v.e_pc = epc; v.e_instr = ein; v.e_addr = ea; v.e_trap = et;
        step(tag, v);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = i;

        //   rv   rpc           rdy  valid data pc            instr   addr  trap
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0,     32'd0,   8'd0,   1'b0); // 0 BOOT
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h0,     32'd0,   8'd1,   1'b0); // 1
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h4,     32'd1,   8'd2,   1'b0); // 2
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h8,     32'd2,   8'd3,   1'b0); // 3
        add(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,     32'd2,   8'd3,   1'b0); // 4 stall
        add(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,     32'd2,   8'd3,   1'b0); // 5
        add(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h8,     32'd2,   8'd3,   1'b0); // 6
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'hC,     32'd3,   8'd4,   1'b0); // 7 release
        add(1'b1, 32'h40,       1'b0, 1'b0, 1'b0, 32'h0,     32'd0,   8'd16,  1'b0); // 8 redirect in stall
        add(1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 32'h40,    32'd16,  8'd17,  1'b0); // 9
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h44,    32'd17,  8'd18,  1'b0); // 10
        add(1'b1, 32'h3FC,      1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd255, 1'b0); // 11
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h3FC,   32'd255, 8'd0,   1'b0); // 12
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h400,   32'd0,   8'd1,   1'b0); // 13 alias
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h404,   32'd1,   8'd2,   1'b0); // 14
`ifdef FETCH_MISALIGN_TRAP_EN
        add(1'b1, 32'h42,       1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd2,   1'b1); // 15 trap
        add(1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd2,   1'b1); // 16
        add(1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd2,   1'b1); // 17 ignored
`else
        add(1'b1, 32'h42,       1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd16,  1'b0); // 15 forced aligned
        add(1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 32'h40,    32'd16,  8'd17,  1'b0); // 16
        add(1'b1, 32'h80,       1'b1, 1'b0, 1'b0, 32'h0,     32'd0,   8'd32,  1'b0); // 17
`endif

        rst = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        out_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;

        run_rows(0, vecs.size() - 1);

        // Asynchronous reset mid-cycle: outputs clear with no clock edge.
        #3;
        rst = 1'b1;
        #1;
        chk_zero("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_rows(0, 3);

        // Reset during a stall, then a redirect issued in BOOT.
        one("pre_stall", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h8, 32'd2, 8'd3, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk_zero("rst_stall");
        @(posedge clk);
        #1;
        rst = 1'b0;
        one("boot_redir", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 8'd16, 1'b0);
        one("boot_redir_cap", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h40, 32'd16, 8'd17, 1'b0);

        // PC increment wraps modulo 2^32.
        one("wrap_redir", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h0, 32'd0, 8'd255, 1'b0);
        one("wrap_cap0", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'd255, 8'd0, 1'b0);
        one("wrap_cap1", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'd0, 8'd1, 1'b0);

        // Reset while a redirect is pending: the redirect target must not survive.
        redirect_valid = 1'b1;
        redirect_pc = 32'h80;
        #3;
        rst = 1'b1;
        #1;
        chk_zero("rst_redir");
        @(posedge clk);
        #1;
        rst = 1'b0;
        one("post_rst_boot", 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0, 8'd0, 1'b0);
        one("post_rst_cap", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0, 32'd0, 8'd1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
